// File: rtl/phy_tx_arbiter_if.sv
// rtl/phy_tx_arbiter_if.sv - stream bundle joining the two packet sources, the arbiter and the framer
// Signal names are seen from the arbiter: i_ are arbiter inputs, o_ are arbiter outputs.
interface phy_tx_arbiter_if;
    logic        i_s0_valid;
    logic [3:0]  i_s0_keep;
    logic [31:0] i_s0_data;
    logic        i_s0_last;
    logic        o_s0_ready;
    logic        i_s1_valid;
    logic [3:0]  i_s1_keep;
    logic [31:0] i_s1_data;
    logic        i_s1_last;
    logic        o_s1_ready;
    logic        o_m_valid;
    logic [3:0]  o_m_keep;
    logic [31:0] o_m_data;
    logic        o_m_last;
    logic        i_m_ready;

    modport master (
        input  i_s0_valid, i_s0_keep, i_s0_data, i_s0_last,
        input  i_s1_valid, i_s1_keep, i_s1_data, i_s1_last,
        input  i_m_ready,
        output o_s0_ready, o_s1_ready,
        output o_m_valid, o_m_keep, o_m_data, o_m_last
    );

    modport slave (
        output i_s0_valid, i_s0_keep, i_s0_data, i_s0_last,
        output i_s1_valid, i_s1_keep, i_s1_data, i_s1_last,
        output i_m_ready,
        input  o_s0_ready, o_s1_ready,
        input  o_m_valid, o_m_keep, o_m_data, o_m_last
    );
endinterface

// File: rtl/phy_tx_arbiter.sv
// rtl/phy_tx_arbiter.sv - packet-granular 2:1 arbiter with a post-packet idle gap ahead of the PHY TX framer
// Define PHY_TX_ARB_STRICT_PRIO_EN to give ch0 fixed priority on ties instead of round-robin.
module phy_tx_arbiter #(
    parameter int P_GAP_CYCLES = 4,
    parameter int P_CNT_W      = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_gt_tx_done,
    phy_tx_arbiter_if.master   io_axis,
    output logic [1:0]         o_grant,
    output logic               o_busy,
    output logic [P_CNT_W-1:0] o_pkt_cnt0,
    output logic [P_CNT_W-1:0] o_pkt_cnt1
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0]         LP_GAP_LAST = 8'(P_GAP_CYCLES - 1);
    localparam logic [P_CNT_W-1:0] LP_CNT_ONE  = P_CNT_W'(1);

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_grant, w_grant_nxt;
    logic               r_last_grant;
    logic [7:0]         r_gap_cnt, w_gap_cnt_nxt;
    logic [P_CNT_W-1:0] r_pkt_cnt0, r_pkt_cnt1;
    logic               w_pick_ch1;
    logic               w_beat;
    logic               w_pkt_done;
    logic               w_m_valid, w_m_last;
    logic [3:0]         w_m_keep;
    logic [31:0]        w_m_data;
    logic               w_s0_ready, w_s1_ready;

    // r_last_grant=1 means ch1 owned the most recent packet, so ch0 takes the next tie.
`ifdef PHY_TX_ARB_STRICT_PRIO_EN
    assign w_pick_ch1 = !io_axis.i_s0_valid;
`else
    assign w_pick_ch1 = io_axis.i_s1_valid && (!io_axis.i_s0_valid || !r_last_grant);
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gap_cnt_nxt = r_gap_cnt;
        w_m_valid     = 1'b0;
        w_m_last      = 1'b0;
        w_m_keep      = '0;
        w_m_data      = '0;
        w_s0_ready    = 1'b0;
        w_s1_ready    = 1'b0;
        w_beat        = 1'b0;
        w_pkt_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_gt_tx_done && (io_axis.i_s0_valid || io_axis.i_s1_valid)) begin
                    w_grant_nxt = w_pick_ch1 ? 2'b10 : 2'b01;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                // Owner stays until its last beat, regardless of i_gt_tx_done or valid gaps.
                if (r_grant[1]) begin
                    w_m_valid  = io_axis.i_s1_valid;
                    w_m_last   = io_axis.i_s1_last;
                    w_m_keep   = io_axis.i_s1_keep;
                    w_m_data   = io_axis.i_s1_data;
                    w_s1_ready = io_axis.i_m_ready;
                end else begin
                    w_m_valid  = io_axis.i_s0_valid;
                    w_m_last   = io_axis.i_s0_last;
                    w_m_keep   = io_axis.i_s0_keep;
                    w_m_data   = io_axis.i_s0_data;
                    w_s0_ready = io_axis.i_m_ready;
                end
                w_beat = w_m_valid && io_axis.i_m_ready;
                if (w_beat && w_m_last) begin
                    w_pkt_done  = 1'b1;
                    w_grant_nxt = 2'b00;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == LP_GAP_LAST) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;
            r_gap_cnt    <= '0;
            r_pkt_cnt0   <= '0;
            r_pkt_cnt1   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            if (w_pkt_done) begin
                r_last_grant <= r_grant[1];
                if (r_grant[1]) begin
                    r_pkt_cnt1 <= r_pkt_cnt1 + LP_CNT_ONE;
                end else begin
                    r_pkt_cnt0 <= r_pkt_cnt0 + LP_CNT_ONE;
                end
            end
        end
    end

    assign io_axis.o_m_valid  = w_m_valid;
    assign io_axis.o_m_last   = w_m_last;
    assign io_axis.o_m_keep   = w_m_keep;
    assign io_axis.o_m_data   = w_m_data;
    assign io_axis.o_s0_ready = w_s0_ready;
    assign io_axis.o_s1_ready = w_s1_ready;
    assign o_grant            = r_grant;
    assign o_busy             = (r_state != ST_IDLE);
    assign o_pkt_cnt0         = r_pkt_cnt0;
    assign o_pkt_cnt1         = r_pkt_cnt1;
endmodule

// File: tb/tb_phy_tx_arbiter.sv
// tb/tb_phy_tx_arbiter.sv - randomized self-checking bench for phy_tx_arbiter against a packet-level model
module tb_phy_tx_arbiter;
    localparam int P_GAP = 4;
    localparam int CW    = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          gt;
    logic [1:0]    grant;
    logic          busy;
    logic [CW-1:0] cnt0, cnt1;

    phy_tx_arbiter_if bus();

    phy_tx_arbiter #(.P_GAP_CYCLES(P_GAP), .P_CNT_W(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_gt_tx_done (gt),
        .io_axis      (bus),
        .o_grant      (grant),
        .o_busy       (busy),
        .o_pkt_cnt0   (cnt0),
        .o_pkt_cnt1   (cnt1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    beat_t      q0[$], q1[$];
    bit         pres0, pres1;
    int         idle_pct, rdy_mode;
    bit         gt_rand;
    int         cyc, end_cyc, owner, last_win, exp_cnt0, exp_cnt1, beats_seen;
    logic [1:0] grant_log[$];
    logic [1:0] prev_grant;

    task automatic model_reset();
        owner      = -1;
        last_win   = 1;
        end_cyc    = cyc - 1000;
        exp_cnt0   = 0;
        exp_cnt1   = 0;
        prev_grant = 2'b00;
        grant_log.delete();
    endtask

    task automatic clear_sources();
        q0.delete();
        q1.delete();
        pres0 = 1'b0;
        pres1 = 1'b0;
        bus.i_s0_valid = 1'b0; bus.i_s0_data = '0; bus.i_s0_keep = '0; bus.i_s0_last = 1'b0;
        bus.i_s1_valid = 1'b0; bus.i_s1_data = '0; bus.i_s1_keep = '0; bus.i_s1_last = 1'b0;
    endtask

    task automatic push_pkt(input int ch, input int len, input logic [3:0] keep_last);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.keep = (i == len - 1) ? keep_last : 4'($urandom_range(15));
            b.last = (i == len - 1);
            if (ch == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    task automatic drive();
        if (q0.size() > 0 && !pres0) pres0 = ($urandom_range(99) >= idle_pct);
        if (q1.size() > 0 && !pres1) pres1 = ($urandom_range(99) >= idle_pct);
        bus.i_s0_valid = pres0;
        bus.i_s1_valid = pres1;
        if (q0.size() > 0) {bus.i_s0_data, bus.i_s0_keep, bus.i_s0_last} = q0[0];
        if (q1.size() > 0) {bus.i_s1_data, bus.i_s1_keep, bus.i_s1_last} = q1[0];
        case (rdy_mode)
            0:       bus.i_m_ready = 1'b1;
            1:       bus.i_m_ready = 1'($urandom_range(1));
            default: bus.i_m_ready = (cyc % 2 == 0);
        endcase
        if (gt_rand) gt = ($urandom_range(9) != 0);
    endtask

    // Mid-cycle check of every observable against the packet-level model, then advance the model.
    task automatic check_cycle();
        logic v0, v1, mr, e_mv, e_busy;
        logic [1:0] eg;
        logic [2*CW+5:0] obs, exp_v;
        beat_t hb, pb;
        v0 = bus.i_s0_valid;
        v1 = bus.i_s1_valid;
        mr = bus.i_m_ready;
        eg = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
        e_mv = (owner == 0) ? v0 : ((owner == 1) ? v1 : 1'b0);
        e_busy = (owner >= 0) || (cyc - end_cyc <= P_GAP);
        obs = {grant, busy, bus.o_m_valid, bus.o_s0_ready, bus.o_s1_ready, cnt0, cnt1};
        exp_v = {eg, e_busy, e_mv, (owner == 0) && mr, (owner == 1) && mr, CW'(exp_cnt0), CW'(exp_cnt1)};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL ctl cyc=%0d got=%h required=%h", cyc, obs, exp_v);
        end
        hb = '0;
        if (owner == 0 && q0.size() > 0) hb = q0[0];
        if (owner == 1 && q1.size() > 0) hb = q1[0];
        if (e_mv && mr) begin
            total++;
            if ({bus.o_m_data, bus.o_m_keep, bus.o_m_last} !== hb) begin
                bad++;
                $display("FAIL beat cyc=%0d got=%h required=%h", cyc,
                         {bus.o_m_data, bus.o_m_keep, bus.o_m_last}, hb);
            end
        end
        if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
        prev_grant = grant;
        if (v0 && bus.o_s0_ready && q0.size() > 0) begin
            pb = q0.pop_front();
            if (pb.last) pres0 = 1'b0;
        end
        if (v1 && bus.o_s1_ready && q1.size() > 0) begin
            pb = q1.pop_front();
            if (pb.last) pres1 = 1'b0;
        end
        if (owner >= 0) begin
            if (e_mv && mr) begin
                beats_seen++;
                if (hb.last) begin
                    if (owner == 0) exp_cnt0 = (exp_cnt0 + 1) % (1 << CW);
                    else            exp_cnt1 = (exp_cnt1 + 1) % (1 << CW);
                    last_win = owner;
                    owner    = -1;
                    end_cyc  = cyc;
                end
            end
        end else if (cyc - end_cyc > P_GAP && gt && (v0 || v1)) begin
`ifdef PHY_TX_ARB_STRICT_PRIO_EN
            owner = v0 ? 0 : 1;
`else
            owner = (v0 && v1) ? (1 - last_win) : (v0 ? 0 : 1);
`endif
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // stop_beats<0: exactly max_cyc cycles; 0: until drained; >0: until that many more beats
    task automatic run(input int max_cyc, input int stop_beats);
        int target;
        target = beats_seen + stop_beats;
        for (int i = 0; i < max_cyc; i++) begin
            if (stop_beats == 0 && q0.size() == 0 && q1.size() == 0 && owner < 0) break;
            if (stop_beats > 0 && beats_seen >= target) break;
            step();
        end
    endtask

    task automatic drain(input string name, input int max_cyc);
        run(max_cyc, 0);
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: beats_left=%0d required=0", name, q0.size() + q1.size());
        end
    endtask

    task automatic do_reset();
        clear_sources();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        model_reset();
    endtask

    task automatic check_zero(input string name);
        logic [47:0] obs;
        obs = {grant, busy, bus.o_m_valid, bus.o_m_last, bus.o_m_keep, bus.o_m_data,
               bus.o_s0_ready, bus.o_s1_ready, cnt0, cnt1};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL %s: outputs=%h required=0", name, obs);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rdy_mode = 0; idle_pct = 0; gt_rand = 0; gt = 1'b1;
        do_reset();
        check_zero("reset_outputs");
        run(3, -1);
    endtask

    task automatic test_single_packet();
        do_reset();
        push_pkt(0, 5, 4'b1111);
        drain("single", 100);
        run(P_GAP + 2, -1);
        check_val("single_cnt0", int'(cnt0), 1);
        check_val("single_grant", (grant_log.size() > 0) ? int'(grant_log[0]) : -1, 1);
        check_val("single_busy", int'(busy), 0);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_log[4];
`ifdef PHY_TX_ARB_STRICT_PRIO_EN
        exp_log[0] = 2'b01; exp_log[1] = 2'b01; exp_log[2] = 2'b10; exp_log[3] = 2'b10;
`else
        exp_log[0] = 2'b01; exp_log[1] = 2'b10; exp_log[2] = 2'b01; exp_log[3] = 2'b10;
`endif
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push_pkt(0, 3, 4'($urandom_range(15)));
            push_pkt(1, 3, 4'($urandom_range(15)));
        end
        drain("rr", 200);
        check_val("rr_ngrants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check_val("rr_grant", (i < grant_log.size()) ? int'(grant_log[i]) : -1, int'(exp_log[i]));
        check_val("rr_cnt0", int'(cnt0), 2);
        check_val("rr_cnt1", int'(cnt1), 2);
    endtask

    task automatic test_ready_toggle();
        do_reset();
        rdy_mode = 2;
        push_pkt(1, 8, 4'b0111);
        drain("toggle", 100);
        check_val("toggle_cnt1", int'(cnt1), 1);
        rdy_mode = 0;
    endtask

    task automatic test_gt_done();
        do_reset();
        gt = 1'b0;
        push_pkt(0, 4, 4'b0011);
        run(6, -1);
        check_val("gt_blocked", int'(grant), 0);
        gt = 1'b1;
        step();
        check_val("gt_grant", int'(grant), 1);
        run(50, 2);
        gt = 1'b0;
        drain("gt_mid", 50);
        check_val("gt_cnt0", int'(cnt0), 1);
        push_pkt(0, 2, 4'b1111);
        run(10, -1);
        check_val("gt_blocked2", int'(grant), 0);
        gt = 1'b1;
        drain("gt_resume", 50);
        check_val("gt_cnt0b", int'(cnt0), 2);
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_pkt(0, 6, 4'b1111);
        run(50, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        check_zero("midrst_outputs");
        clear_sources();
        model_reset();
        push_pkt(1, 3, 4'b0001);
        drain("midrst_next", 50);
        check_val("midrst_cnt0", int'(cnt0), 0);
        check_val("midrst_cnt1", int'(cnt1), 1);
    endtask

    task automatic test_random();
        int n0;
        int ch;
        n0 = 0;
        do_reset();
        rdy_mode = 1; idle_pct = 30; gt_rand = 1;
        for (int i = 0; i < 24; i++) begin
            ch = $urandom_range(1);
            if (ch == 0) n0++;
            push_pkt(ch, $urandom_range(1, 8), 4'($urandom_range(15)));
        end
        drain("random", 4000);
        gt_rand = 0; gt = 1'b1; rdy_mode = 0; idle_pct = 0;
        check_val("random_cnt0", int'(cnt0), n0);
        check_val("random_cnt1", int'(cnt1), 24 - n0);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < (1 << CW) - 1; i++) push_pkt(0, 1, 4'($urandom_range(15)));
        drain("wrap_fill", 8 * (1 << CW));
        check_val("wrap_full", int'(cnt0), (1 << CW) - 1);
        push_pkt(0, 1, 4'b1111);
        drain("wrap_roll", 20);
        check_val("wrap_zero", int'(cnt0), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cyc = 0; beats_seen = 0;
        rdy_mode = 0; idle_pct = 0; gt_rand = 0;
        gt = 1'b1; rst = 1'b1;
        bus.i_m_ready = 1'b0;
        clear_sources();
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_ready_toggle();
        test_gt_done();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
